// File: rtl/program_loader_if.sv
// Host byte stream and control-block programming signals for program_loader.
// Host side: a byte moves on a rising edge where host_valid && host_ready; host_data must be stable while host_valid is high.
interface program_loader_if;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic       ready;
  logic       read_ui_in;
  logic       done_load;
  logic       programming;
  logic [7:0] bus_out;
  logic       bus_out_en;

  modport master (
    output host_data, host_valid, ready, read_ui_in, done_load,
    input  host_ready, programming, bus_out, bus_out_en
  );

  modport slave (
    input  host_data, host_valid, ready, read_ui_in, done_load,
    output host_ready, programming, bus_out, bus_out_en
  );
endinterface

// File: rtl/program_loader.sv
// Host-fed byte FIFO that drives the control block's programming mode for one load session.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a mod-256 sum of every byte driven onto the bus.
module program_loader #(
  parameter int PROG_WORDS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_start,
  program_loader_if.slave  bus,
  output logic [4:0]       words_loaded,
  output logic             prog_done,
  output logic             underrun,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  output logic [7:0]       checksum,
`endif
  output logic [1:0]       fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, LOAD, FINISH} state_t;

  state_t state, state_next;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic        empty, full, push, pop, read_req, last_word;
  logic        start_session, arm_edge, finish_edge;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = bus.host_valid && bus.host_ready;
  assign read_req  = bus.read_ui_in && (state == LOAD);
  // An empty-FIFO read still completes: the bus carries HLT and nothing is popped.
  assign pop       = read_req && !empty;
  assign last_word = (words_loaded == 5'(PROG_WORDS - 1));

  assign bus.host_ready = !full;
  assign bus.bus_out_en = read_req;
  assign bus.bus_out    = empty ? 8'h00 : mem[rd_ptr];
  assign fsm_state      = state;

  always_comb begin
    state_next    = state;
    start_session = 1'b0;
    arm_edge      = 1'b0;
    finish_edge   = 1'b0;
    case (state)
      IDLE: begin
        if (prog_start) begin
          state_next    = ARM;
          start_session = 1'b1;
        end
      end
      ARM: begin
        if (bus.ready) begin
          state_next = LOAD;
          arm_edge   = 1'b1;
        end
      end
      LOAD: begin
        if (bus.done_load && last_word) state_next = FINISH;
      end
      FINISH: begin
        if (bus.ready) begin
          state_next  = IDLE;
          finish_edge = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // programming only moves on T0 edges so the control block sees it stable all cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.programming <= 1'b0;
      prog_done       <= 1'b0;
      words_loaded    <= '0;
      underrun        <= 1'b0;
    end else begin
      if (arm_edge)    bus.programming <= 1'b1;
      if (finish_edge) bus.programming <= 1'b0;

      if (start_session)    prog_done <= 1'b0;
      else if (finish_edge) prog_done <= 1'b1;

      if (start_session)                         words_loaded <= '0;
      else if (bus.done_load && state == LOAD)   words_loaded <= words_loaded + 5'd1;

      if (start_session)          underrun <= 1'b0;
      else if (read_req && empty) underrun <= 1'b1;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                checksum <= '0;
    else if (start_session) checksum <= '0;
    else if (read_req)      checksum <= checksum + bus.bus_out;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.host_data;
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader with a session-level reference model.
module tb_program_loader;

  localparam int PW    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_start = 1'b0;
  logic [4:0] words_loaded;
  logic       prog_done;
  logic       underrun;
  logic [1:0] fsm_state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  program_loader_if bus();

  program_loader #(.PROG_WORDS(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_start   (prog_start),
    .bus          (bus),
    .words_loaded (words_loaded),
    .prog_done    (prog_done),
    .underrun     (underrun),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .fsm_state    (fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bytes_expected = 0;
  int bytes_seen     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_fifo[$];
  bit         m_armed, m_prog, m_done, m_under;
  int         m_words;
  logic [7:0] m_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_armed = 0; m_prog = 0; m_done = 0; m_under = 0;
    m_words = 0; m_sum = 8'h00;
  endtask

  task automatic check_regs();
    check("programming", bus.programming, m_prog);
    check("words_loaded", words_loaded, m_words);
    check("prog_done", prog_done, m_done);
    check("underrun", underrun, m_under);
    check("host_ready", bus.host_ready, m_fifo.size() < DEPTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`endif
  endtask

  // driver: one clock of inputs, plus the model's view of what that edge does
  task automatic step(input bit hv, input logic [7:0] hd, input bit rdy,
                      input bit rd, input bit dl, input bit ps);
    bit idle_pre, arm_pre, load_pre, fin_pre, accept;
    logic [7:0] b;
    @(negedge clk);
    bus.host_valid = hv; bus.host_data = hd; bus.ready = rdy;
    bus.read_ui_in = rd; bus.done_load = dl; prog_start = ps;
    idle_pre = !m_armed && !m_prog;
    arm_pre  = m_armed;
    load_pre = m_prog && (m_words < PW);
    fin_pre  = m_prog && (m_words == PW);
    accept   = hv && (m_fifo.size() < DEPTH);
    if (rd && load_pre) begin
      if (m_fifo.size() > 0) b = m_fifo.pop_front();
      else begin b = 8'h00; m_under = 1; end
      exp_q.push_back(b);
      bytes_expected++;
      m_sum = m_sum + b;
    end
    if (accept) m_fifo.push_back(hd);
    if (dl && load_pre) m_words++;
    if (rdy && arm_pre) begin m_armed = 0; m_prog = 1; end
    if (rdy && fin_pre) begin m_prog = 0; m_done = 1; end
    if (ps && idle_pre) begin
      m_armed = 1; m_words = 0; m_done = 0; m_under = 0; m_sum = 8'h00;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(1, b, 0, 0, 0, 0);
  endtask

  // control block: 7-clock instruction cycles, T0 ready, T3 read, T4 write
  task automatic instr_cycles(input int n, input int host_pct, input int stray_ps_pct, input bit push_at_read);
    bit hv, rd, dl, ps;
    for (int c = 0; c < n; c++) begin
      for (int t = 0; t < 7; t++) begin
        hv = ($urandom_range(0, 99) < host_pct) || (push_at_read && t == 3);
        rd = (t == 3) && m_prog;
        dl = (t == 4) && m_prog;
        ps = $urandom_range(0, 99) < stray_ps_pct;
        step(hv, 8'($urandom), (t == 0), rd, dl, ps);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.host_valid = 0; bus.host_data = 0; bus.ready = 0;
    bus.read_ui_in = 0; bus.done_load = 0; prog_start = 0;
    model_clear();
    #1;
    check("rst_programming", bus.programming, 1'b0);
    check("rst_words_loaded", words_loaded, 5'd0);
    check("rst_host_ready", bus.host_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs();
    check("rst_bus_out_en", bus.bus_out_en, 1'b0);
    check("rst_bus_out", bus.bus_out, 8'h00);
  endtask

  // scoreboard monitor: every driven bus byte must match the next expected byte
  always begin
    logic [7:0] e;
    @(negedge clk);
    #2;
    if (bus.bus_out_en === 1'b1) begin
      bytes_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_out_en: unexpected drive of %0h at %0t", bus.bus_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("bus_out", bus.bus_out, e);
      end
    end
  end

  initial begin
    bus.host_valid = 0; bus.host_data = 0; bus.ready = 0;
    bus.read_ui_in = 0; bus.done_load = 0;
    model_clear();

    do_reset();
    idle_steps(5);

    // directed session: four bytes, then a rejected fifth while full
    push_byte(8'h41);
    push_byte(8'h52);
    push_byte(8'h63);
    push_byte(8'h70);
    check("full_host_ready", bus.host_ready, 1'b0);
    push_byte(8'h99);
    step(0, 8'h00, 0, 0, 0, 1);
    instr_cycles(6, 0, 0, 0);
    check("dir_prog_done", prog_done, 1'b1);
    check("dir_words_loaded", words_loaded, 5'd4);
    check("dir_programming", bus.programming, 1'b0);
    check("dir_underrun", underrun, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("dir_checksum", checksum, 8'h66);
`endif

    // underrun session; first pass pushes on the read edge of an empty FIFO
    step(0, 8'h00, 0, 0, 0, 1);
    instr_cycles(2, 0, 0, 1);
    instr_cycles(4, 0, 0, 0);
    check("ur_underrun", underrun, 1'b1);
    check("ur_words_loaded", words_loaded, 5'd4);

    // reset mid-LOAD after two words, with an ignored prog_start first
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    step(0, 8'h00, 0, 0, 0, 1);
    instr_cycles(2, 0, 0, 0);
    check("mid_words_loaded", words_loaded, 5'd2);
    step(0, 8'h00, 0, 0, 0, 1);
    do_reset();
    idle_steps(3);
    step(0, 8'h00, 0, 0, 0, 1);
    instr_cycles(6, 0, 0, 0);
    check("post_rst_underrun", underrun, 1'b1);

    // randomized sessions with concurrent host traffic and stray prog_start
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) push_byte(8'($urandom));
      step(0, 8'h00, 0, 0, 0, 1);
      instr_cycles(PW + 2, 40, 5, 0);
      idle_steps(int'($urandom_range(0, 3)));
    end

    idle_steps(2);
    check("bytes_delivered", bytes_seen, bytes_expected);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
